// File: rtl/bf16_pkg.sv
// Shared definitions for the bfloat16 comparator: ordering codes, default
// field widths and small classification helpers.
package bf16_pkg;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_UN = 2'b11;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 7;

  // Helpers take pre-reduced field flags so they stay independent of widths.
  function automatic logic is_nan(input logic exp_ones, input logic man_zero);
    return exp_ones & ~man_zero;
  endfunction

  function automatic logic is_zero(input logic exp_zero, input logic man_zero);
    return exp_zero & man_zero;
  endfunction

endpackage

// File: rtl/bf16_cmp_core.sv
// Combinational ordering of two bfloat16-style operands into a 2-bit code.
// NaN wins over everything; signed zeros are equal; same-sign values order by magnitude.
module bf16_cmp_core
  import bf16_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [1:0]           code
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic [W-2:0]     mag_a, mag_b;
  logic             nan_a, nan_b, zero_a, zero_b;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1];
  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  assign man_a  = a[MAN_W-1:0];
  assign man_b  = b[MAN_W-1:0];
  assign mag_a  = a[W-2:0];
  assign mag_b  = b[W-2:0];

  assign nan_a  = is_nan(&exp_a, ~|man_a);
  assign nan_b  = is_nan(&exp_b, ~|man_b);
  assign zero_a = is_zero(~|exp_a, ~|man_a);
  assign zero_b = is_zero(~|exp_b, ~|man_b);

  // {exp,man} is monotonic in magnitude, infinities and subnormals included.
  always_comb begin
    code = CMP_EQ;
    if (nan_a || nan_b) begin
      code = CMP_UN;
    end else if (zero_a && zero_b) begin
      code = CMP_EQ;
    end else if (sign_a != sign_b) begin
      code = sign_a ? CMP_LT : CMP_GT;
    end else if (mag_a == mag_b) begin
      code = CMP_EQ;
    end else if (!sign_a) begin
      code = (mag_a > mag_b) ? CMP_GT : CMP_LT;
    end else begin
      code = (mag_a > mag_b) ? CMP_LT : CMP_GT;
    end
  end

endmodule

// File: rtl/bfloat16_cmp.sv
// Registered bfloat16 comparator: one-cycle latency, a new operand pair every
// cycle, no handshake. out holds the result of the pair sampled at the last edge.
module bfloat16_cmp
  import bf16_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXP_W+MAN_W:0] a1,
  input  logic [EXP_W+MAN_W:0] b1,
  output logic [1:0]           out
);

  logic [1:0] code;

  bf16_cmp_core #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_core (
    .a    (a1),
    .b    (b1),
    .code (code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= CMP_EQ;
    end else begin
      out <= code;
    end
  end

endmodule

// File: tb/tb_bfloat16_cmp.sv
// Bench for bfloat16_cmp: directed table, reset/latency sequence and random
// pairs checked against a real-number ordering model.
module tb_bfloat16_cmp;

  logic        clk;
  logic        rst_n;
  logic [15:0] a1, b1;
  logic [1:0]  out;

  int checks = 0;
  int errors = 0;

  bfloat16_cmp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a1    (a1),
    .b1    (b1),
    .out   (out)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference model: decode to a real value and order numerically.
  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
    else for (int i = 0; i < -e; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic logic ref_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  function automatic real to_real(input logic [15:0] x);
    int  e = int'(x[14:7]);
    int  m = int'(x[6:0]);
    real mag;
    if (e == 255) mag = 1.0e300;
    else if (e == 0) mag = real'(m) * pow2(-133);
    else mag = real'(128 + m) * pow2(e - 134);
    return x[15] ? -mag : mag;
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [15:0] a, input logic [15:0] b);
    real ra, rb;
    if (ref_nan(a) || ref_nan(b)) return 2'b11;
    ra = to_real(a);
    rb = to_real(b);
    if (ra == rb) return 2'b00;
    return (ra > rb) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] x;
    x = 16'($urandom_range(0, 65535));
    case ($urandom_range(0, 9))
      0: x[14:0] = 15'd0;
      1: x[14:0] = 15'h7F80;
      2: begin x[14:7] = 8'hFF; x[6:0] = 7'($urandom_range(1, 127)); end
      3: x[14:7] = 8'h00;
      default: ;
    endcase
    return x;
  endfunction

  // driver: present a pair, let one edge capture it, then sample
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] exp);
    @(negedge clk);
    a1 = a;
    b1 = b;
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  exp;
  } vec_t;

  vec_t dir_tbl[14] = '{
    '{16'h401D, 16'h3F8E, 2'b01}, '{16'hC01D, 16'hBF8E, 2'b10},
    '{16'h0000, 16'h0000, 2'b00}, '{16'hBF99, 16'hBFA6, 2'b01},
    '{16'hBE4C, 16'hBE99, 2'b01}, '{16'hC019, 16'hC013, 2'b10},
    '{16'h0000, 16'h8000, 2'b00}, '{16'h7F80, 16'h7F7F, 2'b01},
    '{16'hFF80, 16'hFF80, 2'b00}, '{16'h7FC0, 16'h3F80, 2'b11},
    '{16'h3F80, 16'hFFC1, 2'b11}, '{16'h0001, 16'h0000, 2'b01},
    '{16'h8001, 16'h0001, 2'b10}, '{16'h3F80, 16'hBF80, 2'b01}
  };

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b1;
    a1    = 16'h0000;
    b1    = 16'h0000;
    #2 rst_n = 1'b0;
    #1 check("reset_state", out, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir_tbl[i])
      apply($sformatf("dir%0d_%h_%h", i, dir_tbl[i].a, dir_tbl[i].b),
            dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].exp);

    // reset mid-cycle clears out without a clock edge
    apply("pre_reset", 16'h401D, 16'h3F8E, 2'b01);
    #5 rst_n = 1'b0;
    #1 check("async_reset", out, 2'b00);
    @(posedge clk); #1 check("reset_hold1", out, 2'b00);
    @(posedge clk); #1 check("reset_hold2", out, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 check("first_after_reset", out, 2'b01);

    // inputs change between edges; out must hold until the next edge
    a1 = 16'h3F8E;
    b1 = 16'h401D;
    #3 check("hold_between_edges", out, 2'b01);
    @(posedge clk); #1 check("after_next_edge", out, 2'b10);

    // random pairs, biased toward equal and near-equal operands
    for (int n = 0; n < 400; n++) begin
      ra = rand_bf16();
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = ra ^ 16'h8000;
        2: rb = ra ^ 16'(1 << $urandom_range(0, 14));
        default: rb = rand_bf16();
      endcase
      apply($sformatf("rand_%h_%h", ra, rb), ra, rb, ref_cmp(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
